// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch/PC-sequencing unit
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_OV = 3'b110;
  localparam logic [2:0] COND_UN = 3'b111;

  // Bit positions inside the {Z,N,V} flag vector.
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - branch condition evaluation on the Z/N/V flags
module branch_cond
  import fetch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NE: taken = !z;
      COND_EQ: taken = z;
      COND_GT: taken = !z && !n;
      COND_LT: taken = n;
      COND_GE: taken = z || (!z && !n);
      COND_LE: taken = n || z;
      COND_OV: taken = v;
      COND_UN: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch and PC sequencing controller
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                STEP     = 2,
  parameter int                OFF_W    = 9,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       inst,
  output logic              inst_valid,
  input  logic              inst_done,
  input  logic              ex_is_b,
  input  logic              ex_is_br,
  input  logic              ex_hlt,
  input  logic [2:0]        ex_cond,
  input  logic [OFF_W-1:0]  ex_off,
  input  logic [ADDR_W-1:0] ex_rs,
  input  logic [2:0]        flag_we,
  input  logic [2:0]        flag_in,
  output logic [2:0]        flags,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic              hlt,
  output logic [CNT_W-1:0]  instret
);

  state_t            state;
  logic              cond_taken;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] b_target;
  logic [ADDR_W-1:0] target;

  // Condition sees the flags as they were before this instruction's own update.
  branch_cond u_branch_cond (
    .cond  (ex_cond),
    .z     (flags[FLAG_Z]),
    .n     (flags[FLAG_N]),
    .v     (flags[FLAG_V]),
    .taken (cond_taken)
  );

  assign off_ext     = {{(ADDR_W-OFF_W){ex_off[OFF_W-1]}}, ex_off};
  assign seq_pc      = pc + ADDR_W'(STEP);
  assign b_target    = seq_pc + (off_ext << 1);
  assign pc_next_seq = seq_pc;
  assign imem_addr   = pc;

  // A B-format instruction never falls through to the BR path, even if not taken.
  always_comb begin
    target = seq_pc;
    if (ex_is_b) begin
      if (cond_taken) target = b_target;
    end else if (ex_is_br && cond_taken) begin
      target = ex_rs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      flags      <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      imem_req   <= 1'b0;
      hlt        <= 1'b0;
      instret    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            inst       <= imem_rdata;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (inst_done) begin
            if (instret != {CNT_W{1'b1}}) instret <= instret + CNT_W'(1);
            flags      <= (flags & ~flag_we) | (flag_in & flag_we);
            inst_valid <= 1'b0;
            if (ex_hlt) begin
              hlt   <= 1'b1;
              state <= ST_HALT;
            end else begin
              pc       <= target;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a transaction-level model
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_done = 1'b0;
  logic        ex_is_b = 1'b0;
  logic        ex_is_br = 1'b0;
  logic        ex_hlt = 1'b0;
  logic [2:0]  ex_cond = '0;
  logic [8:0]  ex_off = '0;
  logic [15:0] ex_rs = '0;
  logic [2:0]  flag_we = '0;
  logic [2:0]  flag_in = '0;
  logic [2:0]  flags;
  logic [15:0] pc;
  logic [15:0] pc_next_seq;
  logic        hlt;
  logic [31:0] instret;

  int errors = 0;
  int checks = 0;
  int cycle_no = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  fetch_ctrl #(
    .ADDR_W(16), .RESET_PC(16'h0000), .STEP(2), .OFF_W(9), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
    .inst_done(inst_done), .ex_is_b(ex_is_b), .ex_is_br(ex_is_br), .ex_hlt(ex_hlt),
    .ex_cond(ex_cond), .ex_off(ex_off), .ex_rs(ex_rs), .flag_we(flag_we), .flag_in(flag_in),
    .flags(flags), .pc(pc), .pc_next_seq(pc_next_seq), .hlt(hlt), .instret(instret)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cycle_no);
    end
  endtask

  // Reference model: phase of the current instruction plus architectural state.
  localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_HALT = 3;
  int          m_ph;
  logic [15:0] m_pc, m_inst;
  logic [2:0]  m_flags;
  logic [31:0] m_ret;

  function automatic logic cond_ok(input logic [2:0] c, input logic [2:0] f);
    logic z, n, v;
    z = f[2]; n = f[1]; v = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] next_pc(input logic [15:0] p, input logic b, input logic br,
                                          input logic ok, input logic [8:0] off, input logic [15:0] rs);
    int o, r;
    o = int'(off);
    if (o >= 256) o = o - 512;
    r = int'(p) + 2;
    if (b) begin
      if (ok) r = int'(p) + 2 + 2 * o;
    end else if (br && ok) begin
      r = int'(rs);
    end
    r = r & 32'hFFFF;
    return r[15:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ph <= P_IDLE; m_pc <= 16'h0000; m_flags <= 3'b000; m_inst <= 16'h0000; m_ret <= 0;
    end else begin
      case (m_ph)
        P_IDLE: m_ph <= P_FETCH;
        P_FETCH: if (imem_ack) begin m_inst <= imem_rdata; m_ph <= P_EXEC; end
        P_EXEC: if (inst_done) begin
          m_ret   <= (m_ret == 32'hFFFF_FFFF) ? m_ret : m_ret + 1;
          m_flags <= (m_flags & ~flag_we) | (flag_in & flag_we);
          if (ex_hlt) m_ph <= P_HALT;
          else begin
            m_pc <= next_pc(m_pc, ex_is_b, ex_is_br, cond_ok(ex_cond, m_flags), ex_off, ex_rs);
            m_ph <= P_FETCH;
          end
        end
        default: m_ph <= P_HALT;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", 32'(imem_req), 32'(m_ph == P_FETCH));
      chk("inst_valid", 32'(inst_valid), 32'(m_ph == P_EXEC));
      chk("hlt", 32'(hlt), 32'(m_ph == P_HALT));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("pc_next_seq", 32'(pc_next_seq), 32'(16'(m_pc + 16'd2)));
      chk("flags", 32'(flags), 32'(m_flags));
      chk("inst", 32'(inst), 32'(m_inst));
      chk("instret", instret, m_ret);
    end
  end

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      imem_ack = 1'($urandom); inst_done = 1'($urandom); imem_rdata = 16'($urandom);
      cyc();
    end
    rst = 1'b0; imem_ack = 1'b0; inst_done = 1'b0;
  endtask

  task automatic wait_req;
    int n = 0;
    while (!imem_req && n < 50) begin
      inst_done = 1'($urandom);
      cyc();
      n++;
    end
    chk("req_wait", 32'(imem_req), 32'd1);
    inst_done = 1'b0;
  endtask

  task automatic run_inst(input logic [15:0] data, input int lat, input int ddly,
                          input logic b, input logic br, input logic h, input logic [2:0] c,
                          input logic [8:0] off, input logic [15:0] rs,
                          input logic [2:0] we, input logic [2:0] fin);
    wait_req();
    repeat (lat) begin imem_ack = 1'b0; inst_done = 1'($urandom); cyc(); end
    imem_ack = 1'b1; imem_rdata = data; inst_done = 1'b0;
    cyc();
    repeat (ddly) begin
      imem_ack = 1'($urandom); imem_rdata = 16'($urandom); inst_done = 1'b0; cyc();
    end
    imem_ack = 1'($urandom); inst_done = 1'b1;
    ex_is_b = b; ex_is_br = br; ex_hlt = h; ex_cond = c; ex_off = off; ex_rs = rs;
    flag_we = we; flag_in = fin;
    cyc();
    inst_done = 1'b0; imem_ack = 1'b0;
    ex_is_b = 1'($urandom); ex_is_br = 1'($urandom); ex_hlt = 1'($urandom);
    ex_cond = 3'($urandom); ex_off = 9'($urandom); ex_rs = 16'($urandom);
    flag_we = 3'($urandom); flag_in = 3'($urandom);
  endtask

  initial begin
    int t_prev;
    int req_seen;
    // Reset sequence with memory acking permanently.
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hA5A5;
    repeat (3) cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_req_c1", 32'(imem_req), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0000);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_hlt", 32'(hlt), 32'd0);
    chk("rst_inst", 32'(inst), 32'h0000);
    cyc();
    chk("rst_req_c2", 32'(imem_req), 32'd1);
    chk("rst_addr_c2", 32'(imem_addr), 32'h0000);
    cyc();
    chk("rst_valid_c3", 32'(inst_valid), 32'd1);
    chk("rst_inst_c3", 32'(inst), 32'hA5A5);
    imem_ack = 1'b0; inst_done = 1'b1;
    cyc();
    inst_done = 1'b0;
    chk("first_seq_pc", 32'(pc), 32'h0002);

    // Sequential stream with three wait cycles per fetch.
    do_reset(2);
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      run_inst(16'(16'h1000 + k), 3, 0, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'd0, 3'd0, 3'd0);
      chk("seq_pc", 32'(pc), 32'(2 * (k + 1)));
      if (k > 0) chk("seq_cycles", 32'(cycle_no - t_prev), 32'd5);
      t_prev = cycle_no;
    end
    chk("seq_instret", instret, 32'd4);

    // B taken backward from 0x0010, then not taken.
    run_inst(16'h2000, 0, 0, 1'b0, 1'b1, 1'b0, 3'd7, 9'd0, 16'h0010, 3'b100, 3'b100);
    chk("br_to_10", 32'(pc), 32'h0010);
    run_inst(16'h2001, 1, 1, 1'b1, 1'b0, 1'b0, 3'b001, 9'h1FC, 16'hFFFF, 3'd0, 3'd0);
    chk("b_taken", 32'(imem_addr), 32'h000A);
    run_inst(16'h2002, 0, 0, 1'b0, 1'b1, 1'b0, 3'd7, 9'd0, 16'h0010, 3'b100, 3'b000);
    run_inst(16'h2003, 0, 0, 1'b1, 1'b0, 1'b0, 3'b001, 9'h1FC, 16'hFFFF, 3'd0, 3'd0);
    chk("b_not_taken", 32'(imem_addr), 32'h0012);

    // BR whose condition uses pre-update flags.
    run_inst(16'h3000, 2, 0, 1'b0, 1'b1, 1'b0, 3'b000, 9'd0, 16'h1234, 3'b100, 3'b100);
    chk("br_flagwrite_pc", 32'(pc), 32'h1234);
    chk("br_flagwrite_flags", 32'(flags), 32'b100);

    // Address wrap and halt.
    run_inst(16'h4000, 0, 0, 1'b0, 1'b1, 1'b0, 3'd7, 9'd0, 16'hFFFE, 3'd0, 3'd0);
    run_inst(16'h4001, 0, 0, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'd0, 3'd0, 3'd0);
    chk("wrap_pc", 32'(pc), 32'h0000);
    run_inst(16'h4002, 0, 0, 1'b0, 1'b0, 1'b1, 3'd0, 9'd0, 16'd0, 3'd0, 3'd0);
    req_seen = 0;
    repeat (20) begin
      imem_ack = 1'($urandom); inst_done = 1'($urandom);
      if (imem_req) req_seen++;
      cyc();
    end
    imem_ack = 1'b0; inst_done = 1'b0;
    chk("halt_hlt", 32'(hlt), 32'd1);
    chk("halt_req_cycles", 32'(req_seen), 32'd0);
    chk("halt_pc", 32'(pc), 32'h0000);
    do_reset(1);
    chk("unhalt_hlt", 32'(hlt), 32'd0);
    chk("unhalt_req_idle", 32'(imem_req), 32'd0);
    cyc();
    chk("unhalt_req_fetch", 32'(imem_req), 32'd1);

    // Reset coinciding with a fetch acknowledge.
    run_inst(16'h5000, 0, 0, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'd0, 3'd0, 3'd0);
    run_inst(16'h5001, 0, 0, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'd0, 3'b111, 3'b111);
    wait_req();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    cyc();
    rst = 1'b0; imem_ack = 1'b0;
    chk("midfetch_inst", 32'(inst), 32'h0000);
    chk("midfetch_pc", 32'(pc), 32'h0000);
    chk("midfetch_instret", instret, 32'd0);
    chk("midfetch_valid", 32'(inst_valid), 32'd0);

    // Randomized instruction stream, checked every cycle by the model.
    for (int i = 0; i < 250; i++) begin
      logic h;
      if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 2));
      h = ($urandom_range(0, 19) == 0);
      run_inst(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
               1'($urandom), 1'($urandom), h, 3'($urandom), 9'($urandom), 16'($urandom),
               3'($urandom), 3'($urandom));
      if (h) begin
        repeat ($urandom_range(1, 4)) begin
          imem_ack = 1'($urandom); inst_done = 1'($urandom); cyc();
        end
        do_reset(1);
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Parametrised instruction-fetch and PC-sequencing unit for the next-generation multi-cycle core. It replaces the bare PC flop and ad-hoc next-PC mux with a four-state controller. The controller owns the PC, the Z/N/V flag register, branch-condition evaluation, the halt state and a retired-instruction counter. It talks to a variable-latency instruction memory over a req/ack handshake and hands each fetched instruction to decode/execute with a valid/done handshake.

## Interface
- ADDR_W, 16, PC and address width
- RESET_PC, 0, PC value loaded on reset
- STEP, 2, PC increment per sequential instruction
- OFF_W, 9, B-format signed offset width
- CNT_W, 32, retired-instruction counter width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high; overrides every other input
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  16  fetched instruction
- inst  out  16  registered current instruction
- inst_valid  out  1  inst valid for execute
- inst_done  in  1  execute finished current instruction; sampled only while inst_valid
- ex_is_b, ex_is_br, ex_hlt  in  1 each  instruction class, valid with inst_done
- ex_cond  in  3  branch condition code
- ex_off  in  OFF_W  B offset (signed, in instructions)
- ex_rs  in  ADDR_W  BR target register value
- flag_we  in  3  {Z,N,V} write enables, valid with inst_done
- flag_in  in  3  {Z,N,V} new values
- flags  out  3  current {Z,N,V}
- pc  out  ADDR_W  PC of current instruction
- pc_next_seq  out  ADDR_W  pc+STEP (for PCS)
- hlt  out  1  core halted
- instret  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: entered on reset; unconditional move to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, inst<=imem_rdata, go to EXEC. Otherwise stay.
- EXEC: inst_valid=1. Without inst_done, stay. On inst_done:
  - instret increments; saturates at all-ones.
  - Flags with flag_we bit set load flag_in; others hold.
  - If ex_hlt: go to HALT, pc unchanged.
  - Otherwise pc<=target and go to FETCH.
- Target selection: B taken -> pc+STEP+(sext(ex_off)<<1); BR taken -> ex_rs as-is, no alignment fix; else pc+STEP.
- All address arithmetic is modulo 2^ADDR_W; wrap is silent.
- Condition codes are shared with the core: 000 NE (!Z), 001 EQ (Z), 010 GT (!Z&!N), 011 LT (N), 100 GE (Z|(!Z&!N)), 101 LE (N|Z), 110 OV (V), 111 always.
- Condition is evaluated on the flags before any same-cycle flag_we update.
- ex_is_b and ex_is_br both high is illegal; B takes priority.
- HALT: hlt=1, imem_req=0, inst_valid=0. Exit only via rst.
- Ignored inputs: imem_ack outside FETCH, and inst_done outside EXEC.

## Timing
- Reset values: pc=RESET_PC, flags=000, inst=0, inst_valid=0, imem_req=0, hlt=0, instret=0, state IDLE.
- Reset asserted in any state, including mid-FETCH with ack pending, takes effect at the next edge. A same-cycle ack or done is discarded.
- First imem_req rises in the 2nd cycle after rst deasserts.
- Zero-wait memory (ack in first FETCH cycle): inst_valid the following cycle.
- Minimum per instruction is 2 cycles, FETCH plus EXEC with same-cycle done.
- pc, flags, instret and hlt change only on the edge ending an EXEC cycle with inst_done. hlt rises on the edge after done of HLT.
- All outputs are registered or decoded from state and registers only. There is no input-to-output combinational path except pc_next_seq, which is derived from pc.

## Structure
- Package fetch_pkg: state enum, condition-code constants (COND_NE..COND_UN), flag bit indices.
- Sub-module branch_cond: combinational (cond, Z, N, V) -> taken. It is reused by the pipelined core.
- Adders use the existing CLA_16bit for the ADDR_W=16 build. A generic add is acceptable otherwise.

## Test plan
- Reset sequence:
  - Stimulus: rst high 3 cycles, then low; imem_ack tied high.
  - Required: imem_req rises on cycle 2 with imem_addr=0000; inst_valid on cycle 3.
- Sequential, 3-cycle memory latency:
  - Stimulus: 4 instructions, done asserted immediately.
  - Required: imem_addr 0,2,4,6; instret=4; each instruction takes 5 cycles.
- B taken backward:
  - Stimulus: pc=0x0010, flags Z=1, cond=001, ex_off=0x1FC (-4).
  - Required: next imem_addr=0x000A.
  - Stimulus, B not taken: same with Z=0.
  - Required: 0x0012.
- BR with same-cycle flag write:
  - Stimulus: flags Z=0, flag_we=100, flag_in=100, cond=000, ex_rs=0x1234.
  - Required: branch taken to 0x1234; flags=100 afterwards.
- Wrap and halt:
  - Stimulus: pc=0xFFFE, sequential instruction.
  - Required: next pc=0x0000.
  - Stimulus: next instruction is HLT.
  - Required: hlt=1, imem_req stays 0 for 20 cycles, pc=0x0000.
  - Stimulus: rst.
  - Required: returns to IDLE.
- Reset mid-fetch:
  - Stimulus: rst asserted in the same cycle as imem_ack.
  - Required: inst stays 0; pc=RESET_PC; instret=0.
